// File: rtl/fifo_fill_ctrl.sv
`default_nettype none
// ============================================================================
// fifo_fill_ctrl : fetches NUM_FIFOS memory words, unpacks word k into FIFO k.
// Optional FILL_STATS_EN macro adds a backpressure stall counter.
// Revision: 1.0
// ============================================================================
module fifo_fill_ctrl #(
  parameter int NUM_FIFOS      = 9,
  parameter int DATA_WIDTH     = 8,
  parameter int ADDR_WIDTH     = 32,
  parameter int BYTES_PER_WORD = 8
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 start_i,
  output logic                                 busy_o,
  output logic                                 done_o,
  output logic [ADDR_WIDTH-1:0]                mem_address_o,
  output logic                                 mem_read_o,
  input  logic                                 mem_waitrequest_i,
  input  logic [BYTES_PER_WORD*DATA_WIDTH-1:0] mem_readdata_i,
  input  logic                                 mem_readdatavalid_i,
  output logic [NUM_FIFOS-1:0]                 wren_o,
  output logic [NUM_FIFOS*DATA_WIDTH-1:0]      datain_o,
  input  logic [NUM_FIFOS-1:0]                 full_i,
  output logic [15:0]                          stall_cycles_o
);

  localparam int WORD_W = BYTES_PER_WORD * DATA_WIDTH;
  localparam int WIDX_W = (NUM_FIFOS > 1) ? $clog2(NUM_FIFOS) : 1;
  localparam int BIDX_W = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;
  localparam logic [WIDX_W-1:0] LAST_WORD = WIDX_W'(NUM_FIFOS - 1);
  localparam logic [BIDX_W-1:0] LAST_BYTE = BIDX_W'(BYTES_PER_WORD - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_REQ    = 3'd1,
    S_WAIT   = 3'd2,
    S_UNPACK = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic [WIDX_W-1:0]   word_idx_q, word_idx_d;
  logic [BIDX_W-1:0]   byte_idx_q, byte_idx_d;
  logic [WORD_W-1:0]   word_q, word_d;
  logic                w_full_cur;
  logic                w_write;
  logic [DATA_WIDTH-1:0] w_byte;

  assign w_full_cur    = full_i[word_idx_q];
  assign w_byte        = word_q[int'(byte_idx_q)*DATA_WIDTH +: DATA_WIDTH];
  assign mem_address_o = ADDR_WIDTH'(word_idx_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      word_idx_q <= '0;
      byte_idx_q <= '0;
      word_q     <= '0;
    end else begin
      state_q    <= state_d;
      word_idx_q <= word_idx_d;
      byte_idx_q <= byte_idx_d;
      word_q     <= word_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    word_idx_d = word_idx_q;
    byte_idx_d = byte_idx_q;
    word_d     = word_q;
    busy_o     = 1'b0;
    done_o     = 1'b0;
    mem_read_o = 1'b0;
    w_write    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d    = S_REQ;
          word_idx_d = '0;
          byte_idx_d = '0;
        end
      end
      S_REQ: begin
        busy_o     = 1'b1;
        mem_read_o = 1'b1;
        if (!mem_waitrequest_i) state_d = S_WAIT;
      end
      S_WAIT: begin
        busy_o = 1'b1;
        if (mem_readdatavalid_i) begin
          word_d     = mem_readdata_i;
          byte_idx_d = '0;
          state_d    = S_UNPACK;
        end
      end
      S_UNPACK: begin
        busy_o = 1'b1;
        // A full destination simply freezes byte_idx, so the entry is retried.
        if (!w_full_cur) begin
          w_write = 1'b1;
          if (byte_idx_q == LAST_BYTE) begin
            byte_idx_d = '0;
            if (word_idx_q == LAST_WORD) begin
              state_d = S_DONE;
            end else begin
              word_idx_d = word_idx_q + 1'b1;
              state_d    = S_REQ;
            end
          end else begin
            byte_idx_d = byte_idx_q + 1'b1;
          end
        end
      end
      S_DONE: begin
        done_o     = 1'b1;
        word_idx_d = '0;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    wren_o   = '0;
    datain_o = '0;
    for (int i = 0; i < NUM_FIFOS; i++) begin
      if (w_write && (word_idx_q == WIDX_W'(i))) begin
        wren_o[i]                            = 1'b1;
        datain_o[i*DATA_WIDTH +: DATA_WIDTH] = w_byte;
      end
    end
  end

`ifdef FILL_STATS_EN
  logic [15:0] stall_q, stall_d;

  always_comb begin
    stall_d = stall_q;
    if (state_q == S_IDLE && start_i) begin
      stall_d = '0;
    end else if (state_q == S_UNPACK && w_full_cur && stall_q != 16'hFFFF) begin
      stall_d = stall_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stall_q <= '0;
    else        stall_q <= stall_d;
  end

  assign stall_cycles_o = stall_q;
`else
  assign stall_cycles_o = 16'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fifo_fill_ctrl.sv
`default_nettype none
// tb_fifo_fill_ctrl : directed scoreboard bench for fifo_fill_ctrl.
module tb_fifo_fill_ctrl;
  localparam int NF = 9;
  localparam int DW = 8;
  localparam int AW = 32;
  localparam int BPW = 8;
  localparam int WW = BPW * DW;
`ifdef FILL_STATS_EN
  localparam int EXP_STALL = 4;
`else
  localparam int EXP_STALL = 0;
`endif

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           start = 1'b0;
  logic           waitreq = 1'b0;
  logic           rdv = 1'b0;
  logic [WW-1:0]  rdata = '0;
  logic [NF-1:0]  full = '0;
  logic           busy, done, mem_read;
  logic [AW-1:0]  mem_address;
  logic [NF-1:0]  wren;
  logic [NF*DW-1:0] datain;
  logic [15:0]    stall_cycles;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int seq_start = 0;

  typedef struct { int fifo; logic [7:0] data; } wr_t;
  wr_t wq[$];
  int  dq[$];

  fifo_fill_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start_i(start), .busy_o(busy), .done_o(done),
    .mem_address_o(mem_address), .mem_read_o(mem_read),
    .mem_waitrequest_i(waitreq), .mem_readdata_i(rdata),
    .mem_readdatavalid_i(rdv), .wren_o(wren), .datain_o(datain),
    .full_i(full), .stall_cycles_o(stall_cycles)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [WW-1:0] mk_word(input int addr);
    logic [WW-1:0] w;
    for (int b = 0; b < BPW; b++) w[b*DW +: DW] = 8'(addr * BPW + b);
    return w;
  endfunction

  task automatic push_writes(input int nwords, input int extra_bytes);
    wr_t e;
    for (int k = 0; k < nwords; k++)
      for (int b = 0; b < BPW; b++) begin
        e.fifo = k; e.data = 8'(k * BPW + b); wq.push_back(e);
      end
    for (int b = 0; b < extra_bytes; b++) begin
      e.fifo = nwords; e.data = 8'(nwords * BPW + b); wq.push_back(e);
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT writes a FIFO or signals done.
  initial begin
    wr_t e;
    int idx;
    logic [NF*DW-1:0] mask;
    forever begin
      @(negedge clk); #1;
      if (rst_n) begin
        if (wren != '0) begin
          chk("wren_onehot", 128'($onehot(wren)), 128'(1));
          chk("wren_while_full", 128'(|(wren & full)), 128'(0));
          idx = 0;
          for (int i = 0; i < NF; i++) if (wren[i]) idx = i;
          mask = '0;
          mask[idx*DW +: DW] = '1;
          if (wq.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_write actual=fifo%0d data=%0h required=none", idx, datain[idx*DW +: DW]);
          end else begin
            e = wq.pop_front();
            chk("write_fifo", 128'(idx), 128'(e.fifo));
            chk("write_data", 128'(datain[idx*DW +: DW]), 128'(e.data));
            chk("datain_unselected", 128'(datain & ~mask), 128'(0));
          end
        end else begin
          chk("datain_idle", 128'(datain), 128'(0));
        end
        if (done) begin
          chk("busy_at_done", 128'(busy), 128'(0));
          if (dq.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_done actual=1 required=0 cycle=%0d", cyc - seq_start);
          end else begin
            chk("done_latency", 128'(cyc - seq_start), 128'(dq.pop_front()));
          end
        end
      end
    end
  end

  task automatic check_all_zero(input string tag);
    chk({tag, "_busy"},   128'(busy), 128'(0));
    chk({tag, "_done"},   128'(done), 128'(0));
    chk({tag, "_read"},   128'(mem_read), 128'(0));
    chk({tag, "_addr"},   128'(mem_address), 128'(0));
    chk({tag, "_wren"},   128'(wren), 128'(0));
    chk({tag, "_datain"}, 128'(datain), 128'(0));
    chk({tag, "_stall"},  128'(stall_cycles), 128'(0));
  endtask

  // Drives start, memory responses and full flags cycle by cycle from the start cycle.
  task automatic run_seq(input int wait_word, input int wait_n, input int full_lo,
                         input int full_hi, input bit spur, input int rst_at,
                         input int exp_stall);
    int c = 0;
    int wleft = wait_n;
    bit pend = 0;
    int paddr = 0;
    bit pw = 0;
    logic [AW-1:0] prev_addr = '0;
    forever begin
      @(negedge clk);
      if (c == rst_at) begin
        rst_n = 1'b0;
        start = 1'b0; rdv = 1'b0; waitreq = 1'b0; full = '0; rdata = '0;
        #1;
        check_all_zero("reset_mid");
        break;
      end
      if (pw) begin
        chk("held_read", 128'(mem_read), 128'(1));
        chk("held_addr", 128'(mem_address), 128'(prev_addr));
      end
      start = (c == 0) || (spur && (c == 5 || c == 40 || c == 91));
      if (c == 0) seq_start = cyc;
      if (c == 1) begin
        chk("busy_after_start", 128'(busy), 128'(1));
        chk("first_addr", 128'(mem_address), 128'(0));
        chk("stall_cleared", 128'(stall_cycles), 128'(0));
      end
      full = (c >= full_lo && c <= full_hi) ? NF'(1 << 2) : '0;
      rdv = 1'b0; rdata = '0;
      if (pend) begin
        rdv = 1'b1; rdata = mk_word(paddr); pend = 0;
      end else if (spur && mem_read) begin
        rdv = 1'b1; rdata = '1;
      end
      waitreq = 1'b0;
      if (mem_read && int'(mem_address) == wait_word && wleft > 0) begin
        waitreq = 1'b1; wleft--;
      end
      pw = waitreq;
      prev_addr = mem_address;
      if (mem_read && !waitreq) begin
        pend = 1; paddr = int'(mem_address);
      end
      if (done) begin
        @(negedge clk);
        start = 1'b0; rdv = 1'b0; waitreq = 1'b0; full = '0; rdata = '0;
        chk("stall_cycles", 128'(stall_cycles), 128'(exp_stall));
        break;
      end
      c++;
      if (c > 300) begin
        checks++; errors++;
        $display("FAIL timeout actual=no_done required=done cycles=%0d", c);
        start = 1'b0; rdv = 1'b0; waitreq = 1'b0; full = '0;
        break;
      end
    end
  endtask

  initial begin
    repeat (2) @(negedge clk);
    #1;
    check_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    push_writes(NF, 0); dq.push_back(91);
    run_seq(-1, 0, -1, -1, 1'b0, -1, 0);

    push_writes(NF, 0); dq.push_back(96);
    run_seq(3, 5, -1, -1, 1'b0, -1, 0);

    push_writes(NF, 0); dq.push_back(95);
    run_seq(-1, 0, 25, 28, 1'b0, -1, EXP_STALL);

    push_writes(NF, 0); dq.push_back(91);
    run_seq(-1, 0, -1, -1, 1'b1, -1, 0);

    push_writes(4, 2);
    run_seq(-1, 0, -1, -1, 1'b0, 45, 0);
    repeat (3) @(negedge clk);
    chk("reset_pending_writes", 128'(wq.size()), 128'(0));
    rst_n = 1'b1;
    repeat (10) @(negedge clk);

    push_writes(NF, 0); dq.push_back(91);
    run_seq(-1, 0, -1, -1, 1'b0, -1, 0);

    repeat (3) @(negedge clk);
    chk("final_writes_left", 128'(wq.size()), 128'(0));
    chk("final_dones_left", 128'(dq.size()), 128'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/fifo_fill_ctrl.md
FIFO_FILL_CTRL -- requirements
Module: fifo_fill_ctrl

Interface
REQ-001 Parameter NUM_FIFOS, default 9, number of destination FIFOs (8 matrix rows + 1 vector).
REQ-002 Parameter DATA_WIDTH, default 8, FIFO entry width in bits.
REQ-003 Parameter ADDR_WIDTH, default 32, memory word-address width.
REQ-004 Parameter BYTES_PER_WORD, default 8, entries per memory word; memory word width = BYTES_PER_WORD*DATA_WIDTH (64).
REQ-005 clk  input  1  single clock; all state changes on rising edge.
REQ-006 rst_n  input  1  reset, asynchronous, active-low.
REQ-007 start  input  1  begin a fill sequence.
REQ-008 busy  output  1  high from the cycle after an accepted start until done.
REQ-009 done  output  1  one-cycle completion pulse.
REQ-010 mem_address  output  ADDR_WIDTH  word address = current word index.
REQ-011 mem_read  output  1  read request.
REQ-012 mem_waitrequest  input  1  memory stall; request held while high.
REQ-013 mem_readdata  input  BYTES_PER_WORD*DATA_WIDTH  read data.
REQ-014 mem_readdatavalid  input  1  mem_readdata valid this cycle.
REQ-015 wren  output  NUM_FIFOS  per-FIFO write enable.
REQ-016 datain  output  NUM_FIFOS*DATA_WIDTH  per-FIFO write data; slice i feeds FIFO i.
REQ-017 full  input  NUM_FIFOS  per-FIFO full flag.
REQ-018 stall_cycles  output  16  backpressure stall count (see Configuration).

Function
REQ-019 The FSM SHALL have states IDLE, REQ, WAIT, UNPACK, DONE.
REQ-020 IDLE: start=1 -> REQ with word_idx=0; start in any other state SHALL be ignored.
REQ-021 REQ: mem_read=1, mem_address=word_idx; both held stable while mem_waitrequest=1; mem_waitrequest=0 -> WAIT.
REQ-022 WAIT: mem_read=0; on mem_readdatavalid=1 capture mem_readdata into a word register, byte_idx=0 -> UNPACK; mem_readdatavalid outside WAIT SHALL be ignored.
REQ-023 UNPACK with full[word_idx]=0: wren[word_idx]=1, datain slice word_idx = captured bits [byte_idx*8+7 : byte_idx*8] (byte 0 first), byte_idx increments.
REQ-024 UNPACK with full[word_idx]=1: wren all zero, byte_idx held; no entry dropped or duplicated.
REQ-025 wren and datain SHALL be combinational from registered state and the same-cycle full; at most one wren bit high; unselected datain slices zero.
REQ-026 After byte BYTES_PER_WORD-1 is written: word_idx=NUM_FIFOS-1 -> DONE, else word_idx+1 -> REQ.
REQ-027 DONE: done=1 for exactly one cycle, busy=0, -> IDLE.
REQ-028 Unstalled latency: start sampled in cycle 0; word k REQ in cycle 1+10k; data writes in cycles 3+10k..10+10k; done in cycle 91.

Reset
REQ-029 rst_n=0 SHALL immediately force IDLE, word_idx=0, byte_idx=0, busy=0, done=0, mem_read=0, mem_address=0, wren=0, datain=0, stall_cycles=0.
REQ-030 Reset mid-sequence SHALL abandon the sequence; no writes resume after release until a new start.

Configuration
REQ-031 Macro FILL_STATS_EN defined: stall_cycles counts UNPACK cycles with full[word_idx]=1, saturates at 16'hFFFF, clears on accepted start, holds after done.
REQ-032 FILL_STATS_EN undefined: no counter logic; stall_cycles tied to 0.

Verification
REQ-033 start, waitrequest=0, readdatavalid one cycle after request, word k = bytes k*8..k*8+7 -> FIFO k receives k*8..k*8+7 in order; done in cycle 91.
REQ-034 mem_waitrequest=1 for 5 cycles on word 3 -> mem_read/mem_address=3 stable throughout; data identical to REQ-033; done delayed 5 cycles.
REQ-035 full[2]=1 for 4 cycles mid word 2 -> wren=0 during stall, no lost/duplicated byte; with FILL_STATS_EN stall_cycles=4, without =0.
REQ-036 start pulsed while busy, spurious readdatavalid in REQ -> ignored; sequence and final contents unchanged.
REQ-037 rst_n=0 during word 4 UNPACK -> all outputs zero immediately; no wren until new start; new sequence restarts at word 0.
